// File: rtl/int_arbiter_pkg.sv
// Shared definitions for the peripheral interrupt arbiter: FSM state
// encodings, configuration register addresses and default widths.
package int_arbiter_pkg;

    localparam int DEF_INT_CODE_WIDTH = 4;
    localparam int DEF_XLEN           = 32;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_PRESENT = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] IRQ_CFG_EN   = 2'd0;
    localparam logic [1:0] IRQ_CFG_PEND = 2'd1;
    localparam logic [1:0] IRQ_CFG_STAT = 2'd2;
    localparam logic [1:0] IRQ_CFG_MODE = 2'd3;

    // Width of an index into a vector of n entries (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_prio_sel.sv
// Combinational request picker. In fixed mode the lowest set index wins; in
// round-robin mode the search starts at rr_ptr and wraps past the top entry.
// Shared between the peripheral and software interrupt paths.
module int_prio_sel
    import int_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               mode,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // Scan from the farthest search position down to the nearest so the
    // last hit written is the first one in search order.
    always_comb begin
        int         pos;
        logic [IDX_W-1:0] pos_idx;
        valid   = |req;
        index   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = mode ? (int'(rr_ptr) + k) : k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                index = pos_idx;
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// Peripheral interrupt arbiter: captures rising edges on the source lines,
// masks them, picks one winner and walks it through claim and complete.
// Only one peripheral interrupt is outstanding at any time.
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int NUM_SRC        = 8,
    parameter int INT_CODE_WIDTH = DEF_INT_CODE_WIDTH,
    parameter int XLEN           = DEF_XLEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic                      claim,
    input  logic                      complete,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_addr,
    input  logic [XLEN-1:0]           cfg_wdata,
    output logic [XLEN-1:0]           cfg_rdata,
    output logic [INT_CODE_WIDTH-1:0] int_code,
    output logic                      busy
);

    localparam int IDX_W = idx_width(NUM_SRC);

    logic [NUM_SRC-1:0]        irq_prev_q, irq_prev_d;
    logic [NUM_SRC-1:0]        pending_q, pending_d;
    logic [NUM_SRC-1:0]        enable_q, enable_d;
    logic                      mode_q, mode_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]          winner_q, winner_d;
    irq_state_e                state_q, state_d;
    logic [INT_CODE_WIDTH-1:0] int_code_q, int_code_d;

    logic [NUM_SRC-1:0]        rise;
    logic [NUM_SRC-1:0]        w1c;
    logic [NUM_SRC-1:0]        claim_clr;
    logic [NUM_SRC-1:0]        cand;
    logic [NUM_SRC-1:0]        cand_next;
    logic                      sel_valid;
    logic [IDX_W-1:0]          sel_index;
    logic                      unused_wdata;

    assign unused_wdata = ^cfg_wdata[XLEN-1:NUM_SRC];

    // Edge detection and pending bookkeeping; a new edge beats any clear.
    always_comb begin
        irq_prev_d = src_irq;
        rise       = src_irq & ~irq_prev_q;
        w1c        = '0;
        if (cfg_we && (cfg_addr == IRQ_CFG_PEND)) begin
            w1c = cfg_wdata[NUM_SRC-1:0];
        end
        pending_d  = (pending_q & ~w1c & ~claim_clr) | rise;
    end

    // Enable and mode registers written through the config port.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        if (cfg_we) begin
            case (cfg_addr)
                IRQ_CFG_EN:   enable_d = cfg_wdata[NUM_SRC-1:0];
                IRQ_CFG_MODE: mode_d   = cfg_wdata[0];
                default:      ;
            endcase
        end
    end

    // Candidates seen by the picker, plus the view after this cycle's
    // config write so a presented winner is withdrawn without delay.
    always_comb begin
        cand      = pending_q & enable_q;
        cand_next = enable_d & ((pending_q & ~w1c) | rise);
    end

    int_prio_sel #(
        .NUM_REQ (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_sel (
        .req    (cand),
        .rr_ptr (rr_ptr_q),
        .mode   (mode_q),
        .valid  (sel_valid),
        .index  (sel_index)
    );

    // Interrupt sequencing: pick in IDLE, hold the code in PRESENT, wait for
    // the handler in SERVICE. A claim wins over a simultaneous loss.
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        rr_ptr_d   = rr_ptr_q;
        int_code_d = int_code_q;
        claim_clr  = '0;
        case (state_q)
            IRQ_IDLE: begin
                int_code_d = '0;
                if (sel_valid) begin
                    winner_d   = sel_index;
                    state_d    = IRQ_PRESENT;
                    int_code_d = INT_CODE_WIDTH'(sel_index) + INT_CODE_WIDTH'(1);
                end
            end
            IRQ_PRESENT: begin
                if (claim) begin
                    claim_clr  = NUM_SRC'(1) << winner_q;
                    state_d    = IRQ_SERVICE;
                    int_code_d = '0;
                end else if (!cand_next[winner_q]) begin
                    state_d    = IRQ_IDLE;
                    int_code_d = '0;
                end
            end
            IRQ_SERVICE: begin
                int_code_d = '0;
                if (complete) begin
                    state_d  = IRQ_IDLE;
                    rr_ptr_d = (winner_q == IDX_W'(NUM_SRC - 1)) ? '0
                                                                 : winner_q + IDX_W'(1);
                end
            end
            default: begin
                state_d    = IRQ_IDLE;
                int_code_d = '0;
            end
        endcase
    end

    // State registers; reset samples the source lines so a line already
    // high when reset releases is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_prev_q <= src_irq;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= 1'b0;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            state_q    <= IRQ_IDLE;
            int_code_q <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
            state_q    <= state_d;
            int_code_q <= int_code_d;
        end
    end

    assign int_code = int_code_q;
    assign busy     = (state_q == IRQ_SERVICE);

    // Config read mux; unused bits read as zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            IRQ_CFG_EN:   cfg_rdata[NUM_SRC-1:0] = enable_q;
            IRQ_CFG_PEND: cfg_rdata[NUM_SRC-1:0] = pending_q;
            IRQ_CFG_STAT: cfg_rdata[IDX_W+2:0]   = {busy, state_q, winner_q};
            IRQ_CFG_MODE: cfg_rdata[0]           = mode_q;
            default:      cfg_rdata              = '0;
        endcase
    end

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed scenarios against fixed
// expectations, then random traffic against a behavioural model.
module tb_int_arbiter;
    import int_arbiter_pkg::*;

    localparam int N  = 8;
    localparam int CW = DEF_INT_CODE_WIDTH;
    localparam int XW = DEF_XLEN;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  src_irq;
    logic          claim;
    logic          complete;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [XW-1:0] cfg_wdata;
    logic [XW-1:0] cfg_rdata;
    logic [CW-1:0] int_code;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [N-1:0] m_pend, m_en, m_prev;
    logic         m_mode;
    int           m_rr, m_win, m_state;

    int_arbiter #(.NUM_SRC(N), .INT_CODE_WIDTH(CW), .XLEN(XW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_irq   (src_irq),
        .claim     (claim),
        .complete  (complete),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .int_code  (int_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int pick(input logic [N-1:0] c, input int rr, input logic m);
        for (int k = 0; k < N; k++) begin
            int i;
            i = m ? (rr + k) % N : k;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [XW-1:0] m_rdata(input logic [1:0] a);
        logic [XW-1:0] r;
        r = '0;
        case (a)
            2'd0: r[N-1:0] = m_en;
            2'd1: r[N-1:0] = m_pend;
            2'd2: begin
                r[2:0] = m_win[2:0];
                r[4:3] = m_state[1:0];
                r[5]   = (m_state == 2);
            end
            default: r[0] = m_mode;
        endcase
        return r;
    endfunction

    function automatic int m_code();
        return (m_state == 1) ? m_win + 1 : 0;
    endfunction

    // One clock: evaluate the model on the pre-edge inputs, clock, commit.
    task automatic tick();
        logic [N-1:0] e, w1c, en_n, cand, clr, live;
        logic         mode_n;
        int           st, win, rr, p;
        e = '0; w1c = '0; en_n = m_en; cand = '0; clr = '0; live = '0;
        mode_n = m_mode; st = m_state; win = m_win; rr = m_rr; p = -1;
        if (rst_n) begin
            e = src_irq & ~m_prev;
            if (cfg_we && cfg_addr == 2'd1) w1c = cfg_wdata[N-1:0];
            if (cfg_we && cfg_addr == 2'd0) en_n = cfg_wdata[N-1:0];
            if (cfg_we && cfg_addr == 2'd3) mode_n = cfg_wdata[0];
            cand = m_pend & m_en;
            live = en_n & ((m_pend & ~w1c) | e);
            case (m_state)
                0: begin
                    p = pick(cand, m_rr, m_mode);
                    if (p >= 0) begin win = p; st = 1; end
                end
                1: begin
                    if (claim) begin clr[m_win] = 1'b1; st = 2; end
                    else if (!live[m_win]) st = 0;
                end
                default: begin
                    if (complete) begin st = 0; rr = (m_win + 1) % N; end
                end
            endcase
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_pend = '0; m_en = '0; m_mode = 1'b0; m_rr = 0; m_win = 0; m_state = 0;
        end else begin
            m_pend = (m_pend & ~w1c & ~clr) | e;
            m_en = en_n; m_mode = mode_n; m_state = st; m_win = win; m_rr = rr;
        end
        m_prev = src_irq;
        claim = 1'b0; complete = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [XW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; src_irq = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (int_code !== 0) begin n_fail++; $display("[TB] FAIL reset_code: got %0d want 0", int_code); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a); #1;
            n_checks++;
            if (cfg_rdata !== '0) begin n_fail++; $display("[TB] FAIL reset_rdata[%0d]: got %h want 0", a, cfg_rdata); end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        cfg_write(2'd0, 32'hFF);
        cfg_write(2'd3, 32'h0);
        src_irq = 8'h24; tick(); src_irq = '0;
        n_checks++;
        if (int_code !== 0) begin n_fail++; $display("[TB] FAIL fp_early: got %0d want 0", int_code); end
        tick();
        n_checks++;
        if (int_code !== 3) begin n_fail++; $display("[TB] FAIL fp_first: got %0d want 3", int_code); end
        claim = 1'b1; tick();
        n_checks++;
        if (int_code !== 0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL fp_claim: code %0d busy %0b want 0/1", int_code, busy); end
        complete = 1'b1; tick();
        n_checks++;
        if (int_code !== 0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL fp_complete: code %0d busy %0b want 0/0", int_code, busy); end
        tick();
        n_checks++;
        if (int_code !== 6) begin n_fail++; $display("[TB] FAIL fp_second: got %0d want 6", int_code); end
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg_write(2'd0, 32'hFF);
        cfg_write(2'd3, 32'h1);
        src_irq = 8'h42; tick(); src_irq = '0; tick();
        n_checks++;
        if (int_code !== 2) begin n_fail++; $display("[TB] FAIL rr_first: got %0d want 2", int_code); end
        claim = 1'b1; tick();
        complete = 1'b1; tick();
        tick();
        n_checks++;
        if (int_code !== 7) begin n_fail++; $display("[TB] FAIL rr_second: got %0d want 7", int_code); end
        cfg_addr = 2'd2; #1;
        n_checks++;
        if (cfg_rdata !== 32'h0E) begin n_fail++; $display("[TB] FAIL rr_status: got %h want 0e", cfg_rdata); end
        claim = 1'b1; tick();
        complete = 1'b1; tick();
        src_irq = 8'h42; tick(); src_irq = '0; tick();
        n_checks++;
        if (int_code !== 2) begin n_fail++; $display("[TB] FAIL rr_wrap: got %0d want 2", int_code); end
    endtask

    task automatic test_masking();
        do_reset();
        src_irq = 8'h08; tick(); src_irq = '0; tick();
        cfg_addr = 2'd1; #1;
        n_checks++;
        if (cfg_rdata !== 32'h08 || int_code !== 0) begin n_fail++; $display("[TB] FAIL mask_pend: pend %h code %0d want 08/0", cfg_rdata, int_code); end
        cfg_write(2'd0, 32'h08);
        tick();
        n_checks++;
        if (int_code !== 4) begin n_fail++; $display("[TB] FAIL mask_enable: got %0d want 4", int_code); end
        cfg_write(2'd0, 32'h00);
        n_checks++;
        if (int_code !== 0) begin n_fail++; $display("[TB] FAIL mask_drop: got %0d want 0", int_code); end
        cfg_addr = 2'd2; #1;
        n_checks++;
        if (cfg_rdata[4:3] !== 2'd0) begin n_fail++; $display("[TB] FAIL mask_state: got %0d want 0", cfg_rdata[4:3]); end
    endtask

    task automatic test_race();
        do_reset();
        cfg_write(2'd0, 32'hFF);
        src_irq = 8'h10; tick(); src_irq = '0; tick();
        claim = 1'b1; tick();
        src_irq = 8'h10; tick(); src_irq = '0; tick();
        cfg_addr = 2'd1; #1;
        n_checks++;
        if (cfg_rdata !== 32'h10 || busy !== 1'b1 || int_code !== 0) begin
            n_fail++; $display("[TB] FAIL race_accum: pend %h busy %0b code %0d want 10/1/0", cfg_rdata, busy, int_code);
        end
        complete = 1'b1; tick(); tick();
        n_checks++;
        if (int_code !== 5) begin n_fail++; $display("[TB] FAIL race_represent: got %0d want 5", int_code); end
        src_irq = 8'h10; claim = 1'b1; tick(); src_irq = '0;
        cfg_addr = 2'd1; #1;
        n_checks++;
        if (cfg_rdata !== 32'h10 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL race_set_wins: pend %h busy %0b want 10/1", cfg_rdata, busy); end
    endtask

    task automatic test_abuse();
        do_reset();
        cfg_write(2'd0, 32'hFF);
        claim = 1'b1; tick();
        cfg_addr = 2'd2; #1;
        n_checks++;
        if (busy !== 1'b0 || int_code !== 0 || cfg_rdata !== '0) begin
            n_fail++; $display("[TB] FAIL abuse_claim_idle: busy %0b code %0d stat %h want 0/0/0", busy, int_code, cfg_rdata);
        end
        src_irq = 8'h01; tick(); src_irq = '0; tick();
        complete = 1'b1; tick();
        n_checks++;
        if (int_code !== 1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abuse_complete_present: code %0d busy %0b want 1/0", int_code, busy); end
        cfg_write(2'd0, 32'h00);
        src_irq = 8'hF0; tick(); src_irq = '0; tick();
        cfg_addr = 2'd1; #1;
        n_checks++;
        if (cfg_rdata !== 32'hF1) begin n_fail++; $display("[TB] FAIL abuse_pend: got %h want f1", cfg_rdata); end
        cfg_write(2'd1, 32'hFF);
        cfg_addr = 2'd1; #1;
        n_checks++;
        if (cfg_rdata !== '0) begin n_fail++; $display("[TB] FAIL abuse_w1c: got %h want 0", cfg_rdata); end
    endtask

    task automatic test_reset_mid_service();
        do_reset();
        cfg_write(2'd0, 32'hFF);
        src_irq = 8'h04; tick(); src_irq = '0; tick();
        claim = 1'b1; tick();
        src_irq = 8'h80; tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_checks++;
        if (int_code !== 0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_out: code %0d busy %0b want 0/0", int_code, busy); end
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a); #1;
            n_checks++;
            if (cfg_rdata !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_rdata[%0d]: got %h want 0", a, cfg_rdata); end
        end
        for (int i = 0; i < 3; i++) tick();
        cfg_addr = 2'd1; #1;
        n_checks++;
        if (cfg_rdata !== '0 || int_code !== 0) begin n_fail++; $display("[TB] FAIL rst_held_high: pend %h code %0d want 0/0", cfg_rdata, int_code); end
        src_irq = '0; tick();
        src_irq = 8'h80; tick();
        cfg_addr = 2'd1; #1;
        n_checks++;
        if (cfg_rdata !== 32'h80) begin n_fail++; $display("[TB] FAIL rst_new_edge: got %h want 80", cfg_rdata); end
        src_irq = '0;
    endtask

    task automatic test_random();
        do_reset();
        cfg_write(2'd0, 32'hFF);
        for (int i = 0; i < 800; i++) begin
            src_irq   = N'($urandom & $urandom & $urandom);
            claim     = ($urandom_range(0, 3) == 0);
            complete  = ($urandom_range(0, 3) == 0);
            cfg_we    = ($urandom_range(0, 11) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = $urandom;
            if (cfg_addr == 2'd0) cfg_wdata = cfg_wdata | 32'hA5;
            tick();
            cfg_addr = 2'($urandom_range(0, 3)); #1;
            n_checks++;
            if (int_code !== CW'(m_code()) || busy !== (m_state == 2) || cfg_rdata !== m_rdata(cfg_addr)) begin
                n_fail++;
                $display("[TB] FAIL random[%0d]: code %0d busy %0b rdata[%0d] %h want %0d/%0b/%h",
                         i, int_code, busy, cfg_addr, cfg_rdata, m_code(), (m_state == 2), m_rdata(cfg_addr));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; src_irq = '0; claim = 1'b0; complete = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        m_pend = '0; m_en = '0; m_prev = '0; m_mode = 1'b0;
        m_rr = 0; m_win = 0; m_state = 0;
        @(negedge clk);
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_masking();
        test_race();
        test_abuse();
        test_reset_mid_service();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
